// File: rtl/rush3d_pkg.sv
// rtl/rush3d_pkg.sv - state encoding and CSR bit-offset helpers shared by the Rush3D dispatch blocks
package rush3d_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_RUN      = 2'd2,
    ST_COMPLETE = 2'd3
  } dispatch_state_e;

  // Sticky done bits sit directly above the request bits.
  function automatic int done_base(input int num_cmds);
    return num_cmds;
  endfunction

  function automatic int busy_bit(input int num_cmds);
    return 2 * num_cmds;
  endfunction

  function automatic int error_bit(input int num_cmds);
    return 2 * num_cmds + 1;
  endfunction

  // Index width for an N-entry channel set, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rush3d_rr_arbiter.sv
// rtl/rush3d_rr_arbiter.sv - combinational round-robin arbiter searching cyclically from last_grant+1
module rush3d_rr_arbiter
  import rush3d_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = idx_width(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_grant_i,
  output logic          valid_o,
  output logic [IW-1:0] grant_o
);

  // Lowest requester overall covers the wrap-around case; the lowest requester
  // above last_grant, if any, overrides it. Descending scans let the lowest win.
  always_comb begin
    valid_o = |req_i;
    grant_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) grant_o = IW'(i);
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i] && (IW'(i) > last_grant_i)) grant_o = IW'(i);
    end
  end

endmodule

// File: rtl/rush3d_command_dispatcher.sv
// rtl/rush3d_command_dispatcher.sv - CSR-driven round-robin command dispatcher; RUN watchdog enabled by RUSH3D_DISPATCH_TIMEOUT_EN
module rush3d_command_dispatcher
  import rush3d_pkg::*;
#(
  parameter  int CSR_WIDTH      = 64,
  parameter  int NUM_CMDS       = 4,
  parameter  int TIMEOUT_CYCLES = 1048576,
  localparam int IW             = idx_width(NUM_CMDS)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [CSR_WIDTH-1:0] control_status_in,
  output logic [CSR_WIDTH-1:0] control_status_out,
  output logic                 control_status_load,
  output logic [NUM_CMDS-1:0]  cmd_req,
  input  logic [NUM_CMDS-1:0]  cmd_done,
  output logic                 busy,
  output logic [IW-1:0]        active_cmd
);

  localparam int            DONE_BASE  = done_base(NUM_CMDS);
  localparam int            BUSY_BIT   = busy_bit(NUM_CMDS);
  localparam logic [IW-1:0] LAST_RESET = IW'(NUM_CMDS - 1);

  if (CSR_WIDTH < 2 * NUM_CMDS + 2 || NUM_CMDS < 1 || NUM_CMDS > 16 || TIMEOUT_CYCLES < 1)
  begin : g_bad_params
    $error("rush3d_command_dispatcher: illegal CSR_WIDTH/NUM_CMDS/TIMEOUT_CYCLES");
  end

  dispatch_state_e state_q, state_d;
  logic [IW-1:0]   active_q, active_d;
  logic [IW-1:0]   last_grant_q, last_grant_d;

  logic [NUM_CMDS-1:0] req_field;
  logic [NUM_CMDS-1:0] done_field;
  logic [NUM_CMDS-1:0] sel;
  logic                arb_valid;
  logic [IW-1:0]       arb_grant;
  logic                run_exit;
  logic                complete_seen;

  assign req_field  = control_status_in[NUM_CMDS-1:0];
  assign done_field = control_status_in[DONE_BASE +: NUM_CMDS];
  assign sel        = NUM_CMDS'(1) << active_q;

  rush3d_rr_arbiter #(.N(NUM_CMDS)) u_arb (
    .req_i        (req_field),
    .last_grant_i (last_grant_q),
    .valid_o      (arb_valid),
    .grant_o      (arb_grant)
  );

`ifdef RUSH3D_DISPATCH_TIMEOUT_EN
  localparam int            ERROR_BIT  = error_bit(NUM_CMDS);
  localparam int            TW         = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] timer_q, timer_d;
  logic          timed_out_q, timed_out_d;
  logic          timer_expired;

  assign timer_expired = (timer_q == TIMER_LAST);

  // Watchdog state: cycles spent in RUN and whether the current COMPLETE is an error exit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      timer_q     <= '0;
      timed_out_q <= 1'b0;
    end else begin
      timer_q     <= timer_d;
      timed_out_q <= timed_out_d;
    end
  end

  // Counter is cleared while issuing so it starts at zero on RUN entry; a real done beats expiry.
  always_comb begin
    timer_d     = timer_q;
    timed_out_d = timed_out_q;
    if (state_q == ST_ISSUE) begin
      timer_d     = '0;
      timed_out_d = 1'b0;
    end else if (state_q == ST_RUN && !cmd_done[active_q]) begin
      if (timer_expired) timed_out_d = 1'b1;
      else               timer_d     = timer_q + 1'b1;
    end
  end

  assign run_exit      = cmd_done[active_q] || timer_expired;
  assign complete_seen = timed_out_q ? control_status_in[ERROR_BIT] : done_field[active_q];
`else
  assign run_exit      = cmd_done[active_q];
  assign complete_seen = done_field[active_q];
`endif

  // State, grant and round-robin pointer registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      active_q     <= '0;
      last_grant_q <= LAST_RESET;
    end else begin
      state_q      <= state_d;
      active_q     <= active_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Next state: each CSR write is held until the CSR is seen to reflect it.
  always_comb begin
    state_d      = state_q;
    active_d     = active_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          active_d = arb_grant;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!req_field[active_q] && control_status_in[BUSY_BIT]) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (run_exit) state_d = ST_COMPLETE;
      end
      ST_COMPLETE: begin
        if (!control_status_in[BUSY_BIT] && complete_seen) begin
          last_grant_d = active_q;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // CSR write word is rebuilt from the live CSR every cycle so concurrent host edits survive.
  always_comb begin
    control_status_out  = '0;
    control_status_load = 1'b0;
    case (state_q)
      ST_ISSUE: begin
        control_status_load              = 1'b1;
        control_status_out               = control_status_in;
        control_status_out[NUM_CMDS-1:0] = req_field & ~sel;
        control_status_out[BUSY_BIT]     = 1'b1;
      end
      ST_COMPLETE: begin
        control_status_load          = 1'b1;
        control_status_out           = control_status_in;
        control_status_out[BUSY_BIT] = 1'b0;
`ifdef RUSH3D_DISPATCH_TIMEOUT_EN
        if (timed_out_q) control_status_out[ERROR_BIT] = 1'b1;
        else             control_status_out[DONE_BASE +: NUM_CMDS] = done_field | sel;
`else
        control_status_out[DONE_BASE +: NUM_CMDS] = done_field | sel;
`endif
      end
      default: ;
    endcase
  end

  assign cmd_req    = (state_q == ST_RUN) ? sel : '0;
  assign busy       = (state_q != ST_IDLE);
  assign active_cmd = active_q;

endmodule

// File: tb/tb_rush3d_command_dispatcher.sv
// tb/tb_rush3d_command_dispatcher.sv - scoreboard bench for rush3d_command_dispatcher with CSR and engine models
`timescale 1ns/1ps
module tb_rush3d_command_dispatcher;

  localparam int CW      = 64;
  localparam int NC      = 4;
  localparam int TO      = 16;
  localparam int ENG_LAT = 10;

  logic          clock    = 1'b0;
  logic          reset_n  = 1'b0;
  logic [CW-1:0] csr      = '0;
  logic [CW-1:0] csr_out;
  logic          load;
  logic [NC-1:0] cmd_req;
  logic [NC-1:0] cmd_done;
  logic [NC-1:0] eng_done = '0;
  logic [NC-1:0] inj_done = '0;
  logic          busy;
  logic [1:0]    active_cmd;
  logic [CW-1:0] host_set = '0;
  logic [CW-1:0] host_clr = '0;
  logic          eng_mute = 1'b0;
  int            eng_cnt [NC];
  int            n_pass   = 0;
  int            n_total  = 0;

  typedef struct {
    int idx;
    int run_len;
    bit err;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          cur;
  bit            cur_v     = 1'b0;
  int            run_cnt   = 0;
  logic [NC-1:0] req_prev  = '0;
  logic          busy_prev = 1'b0;

  assign cmd_done = eng_done | inj_done;

  rush3d_command_dispatcher #(
    .CSR_WIDTH      (CW),
    .NUM_CMDS       (NC),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock               (clock),
    .reset_n             (reset_n),
    .control_status_in   (csr),
    .control_status_out  (csr_out),
    .control_status_load (load),
    .cmd_req             (cmd_req),
    .cmd_done            (cmd_done),
    .busy                (busy),
    .active_cmd          (active_cmd)
  );

  always #5 clock = ~clock;

  // CSR register: dispatcher writes land one cycle later; host edits apply on top.
  always @(posedge clock) csr <= ((load ? csr_out : csr) & ~host_clr) | host_set;

  // Engines: one-cycle done pulse after ENG_LAT cycles of seeing cmd_req.
  always @(posedge clock) begin
    for (int i = 0; i < NC; i++) begin
      if (cmd_req[i] && !eng_mute) begin
        eng_cnt[i]  <= eng_cnt[i] + 1;
        eng_done[i] <= (eng_cnt[i] == ENG_LAT - 2);
      end else begin
        eng_cnt[i]  <= 0;
        eng_done[i] <= 1'b0;
      end
    end
  end

  function automatic logic bitof(input logic [63:0] v, input int b);
    return v[b[5:0]];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic fail_now(input string name, input string act, input string exp);
    n_total++;
    $display("FAIL %s: got %s expected %s", name, act, exp);
  endtask

  task automatic expect_grant(input int idx, input int len, input bit err);
    exp_t e;
    e.idx     = idx;
    e.run_len = len;
    e.err     = err;
    exp_q.push_back(e);
  endtask

  task automatic host_write(input logic [63:0] set_m, input logic [63:0] clr_m);
    @(negedge clock);
    host_set = set_m;
    host_clr = clr_m;
    @(negedge clock);
    host_set = '0;
    host_clr = '0;
  endtask

  task automatic wait_req(input int idx, input int budget);
    int n = 0;
    while (n < budget && cmd_req[idx[1:0]] !== 1'b1) begin
      @(negedge clock);
      n++;
    end
    if (n >= budget) fail_now("wait_req", "cmd_req low", "cmd_req high");
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (n < budget && !(busy == 1'b0 && csr[NC-1:0] == '0 && exp_q.size() == 0 && !cur_v)) begin
      @(negedge clock);
      n++;
    end
    if (n >= budget) fail_now(name, "still busy", "idle");
    @(negedge clock);
  endtask

  // Monitor: pops an expectation at each grant and checks it through to completion.
  always @(negedge clock) begin
    if (!reset_n) begin
      cur_v     = 1'b0;
      run_cnt   = 0;
      req_prev  = '0;
      busy_prev = 1'b0;
    end else begin
      if (load) chk("upper_passthru", csr_out[63:32], csr[63:32]);
      if (cmd_req != '0) chk("req_onehot", $countones(cmd_req), 1);
      if (cmd_req != '0 && req_prev == '0) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_grant", "grant", "none");
        end else begin
          cur     = exp_q.pop_front();
          cur_v   = 1'b1;
          run_cnt = 0;
          chk("grant_vec", cmd_req, 64'(1) << cur.idx);
          chk("grant_active", active_cmd, cur.idx);
          chk("issue_req_cleared", bitof(csr, cur.idx), 0);
          chk("issue_busy_set", csr[8], 1);
        end
      end
      if (cmd_req != '0) run_cnt++;
      if (cmd_req == '0 && req_prev != '0 && cur_v && cur.run_len > 0)
        chk("run_len", run_cnt, cur.run_len);
      if (!busy && busy_prev && cur_v) begin
        chk("complete_busy_clear", csr[8], 0);
        if (cur.err) begin
          chk("timeout_error_set", csr[9], 1);
          chk("timeout_done_clear", bitof(csr, 4 + cur.idx), 0);
        end else begin
          chk("done_bit_set", bitof(csr, 4 + cur.idx), 1);
        end
        cur_v = 1'b0;
      end
      req_prev  = cmd_req;
      busy_prev = busy;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_cmd_req", cmd_req, 0);
    chk("rst_load", load, 0);
    chk("rst_busy", busy, 0);
    chk("rst_active", active_cmd, 0);
    chk("rst_out", csr_out, 0);
    reset_n = 1'b1;

    // All four requests together: strict rotation from index 0.
    for (int i = 0; i < NC; i++) expect_grant(i, ENG_LAT, 1'b0);
    host_write(64'hF, 64'h0);
    wait_idle("all_idle", 400);
    chk("all_done_bits", csr[7:4], 4'hF);
    chk("all_req_clear", csr[3:0], 4'h0);

    // Single command with cycle-exact issue timing.
    host_write(64'h0, 64'hF0);
    expect_grant(0, ENG_LAT, 1'b0);
    host_write(64'h1, 64'h0);
    chk("t1_still_idle", busy, 0);
    @(negedge clock);
    chk("t1_load", load, 1);
    chk("t1_issue_word", csr_out, 64'h100);
    chk("t1_active", active_cmd, 0);
    @(negedge clock);
    chk("t1_req_wait", cmd_req, 0);
    @(negedge clock);
    chk("t1_req_rise", cmd_req, 1);
    wait_idle("t1_idle", 100);
    chk("t1_final_csr", csr, 64'h10);
    chk("t1_busy_low", busy, 0);

    // Requests arriving during RUN plus a foreign done pulse.
    host_write(64'h0, 64'hF0);
    expect_grant(1, ENG_LAT, 1'b0);
    expect_grant(2, ENG_LAT, 1'b0);
    expect_grant(1, ENG_LAT, 1'b0);
    host_write(64'h2, 64'h0);
    wait_req(1, 50);
    repeat (2) @(negedge clock);
    host_write(64'h6, 64'h0);
    inj_done = 4'b1000;
    @(negedge clock);
    inj_done = 4'b0000;
    wait_idle("t3_idle", 300);
    chk("t3_done_bits", csr[7:4], 4'h6);

    // Upper CSR bits owned by the host stay intact.
    host_write(64'hDEADBEEF_0000_0000, 64'hF0);
    expect_grant(3, ENG_LAT, 1'b0);
    host_write(64'h8, 64'h0);
    wait_idle("t4_idle", 100);
    chk("t4_upper", csr[63:32], 32'hDEADBEEF);
    chk("t4_done_bits", csr[7:4], 4'h8);

    // Reset during RUN: immediate abort, pointer back to channel 0.
    host_write(64'h0, 64'hF0);
    expect_grant(1, 0, 1'b0);
    host_write(64'h2, 64'h0);
    wait_req(1, 50);
    host_write(64'h9, 64'h0);
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    chk("abort_cmd_req", cmd_req, 0);
    chk("abort_load", load, 0);
    chk("abort_busy", busy, 0);
    expect_grant(0, ENG_LAT, 1'b0);
    expect_grant(1, ENG_LAT, 1'b0);
    expect_grant(3, ENG_LAT, 1'b0);
    host_write(64'h2, 64'h100);
    @(negedge clock);
    reset_n = 1'b1;
    wait_idle("t5_idle", 400);
    chk("t5_done_bits", csr[7:4], 4'hB);

`ifdef RUSH3D_DISPATCH_TIMEOUT_EN
    // Silent engine: watchdog exits with the error bit instead of done.
    host_write(64'h0, 64'hF0);
    eng_mute = 1'b1;
    expect_grant(2, TO, 1'b1);
    host_write(64'h4, 64'h0);
    wait_idle("t6_idle", 200);
    chk("t6_error", csr[9], 1);
    chk("t6_busy", csr[8], 0);
    chk("t6_done_clear", csr[6], 0);
    eng_mute = 1'b0;
    host_write(64'h0, 64'h200);
`endif

    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
